// File: rtl/array_feed_skewer.sv
`default_nettype none
// ============================================================================
// array_feed_skewer - drains one frame per lane FIFO with a diagonal lane skew
// Rev 1.0
// ============================================================================
module array_feed_skewer #(
  parameter int LANES = 3,
  parameter int FRAME = 7
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [LANES-1:0]   fifo_empty,
  input  logic [8*LANES-1:0] fifo_data,
  output logic [LANES-1:0]   fifo_re,
  output logic [8*LANES-1:0] pe_data,
  output logic [LANES-1:0]   pe_valid,
  output logic               busy,
  output logic               done,
  output logic               stall,
  output logic [15:0]        frame_count
);

  localparam int CYC_W = $clog2(FRAME + LANES - 1);
  localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(FRAME + LANES - 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CYC_W-1:0] cyc, cyc_nxt;
  logic [LANES-1:0] want;
  logic [LANES-1:0] re_q;

  // Lane k owns the read window k .. k+FRAME-1, giving the diagonal skew.
  always_comb begin
    want = '0;
    for (int k = 0; k < LANES; k++) begin
      want[k] = (int'(cyc) >= k) && (int'(cyc) <= k + FRAME - 1);
    end
  end

  always_comb begin
    state_nxt = state;
    cyc_nxt   = cyc;
    fifo_re   = '0;
    stall     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          cyc_nxt   = '0;
        end
      end
      RUN: begin
        // Any due lane running dry freezes every lane so the skew survives.
        stall = |(want & fifo_empty);
        if (!stall) begin
          fifo_re = want;
          if (cyc == LAST_CYC) begin
            state_nxt = FLUSH;
          end else begin
            cyc_nxt = cyc + 1'b1;
          end
        end
      end
      FLUSH: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      cyc         <= '0;
      re_q        <= '0;
      pe_valid    <= '0;
      pe_data     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      frame_count <= '0;
    end else begin
      state    <= state_nxt;
      cyc      <= cyc_nxt;
      re_q     <= fifo_re;
      pe_valid <= re_q;
      for (int k = 0; k < LANES; k++) begin
        if (re_q[k]) begin
          pe_data[8*k +: 8] <= fifo_data[8*k +: 8];
        end
      end
      busy <= (state_nxt != IDLE);
      done <= (state == FLUSH);
      if (state == FLUSH) begin
        frame_count <= frame_count + 16'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_array_feed_skewer.sv
`default_nettype none
// Scoreboard bench for array_feed_skewer: lane FIFO models feed the DUT,
// expected bytes and frame counts are queued at stimulus time and popped by a monitor.
module tb_array_feed_skewer;

  localparam int LANES = 3;
  localparam int FRAME = 7;

  logic               clk = 1'b0;
  logic               resetn = 1'b0;
  logic               start = 1'b0;
  logic [LANES-1:0]   fifo_empty;
  logic [8*LANES-1:0] fifo_data;
  logic [LANES-1:0]   fifo_re;
  logic [8*LANES-1:0] pe_data;
  logic [LANES-1:0]   pe_valid;
  logic               busy;
  logic               done;
  logic               stall;
  logic [15:0]        frame_count;

  array_feed_skewer #(.LANES(LANES), .FRAME(FRAME)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .start       (start),
    .fifo_empty  (fifo_empty),
    .fifo_data   (fifo_data),
    .fifo_re     (fifo_re),
    .pe_data     (pe_data),
    .pe_valid    (pe_valid),
    .busy        (busy),
    .done        (done),
    .stall       (stall),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc_n    = 0;
  int          rd_cnt   = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          busy_cnt = 0;
  logic [7:0]  fq  [LANES][$];
  logic [7:0]  exq [LANES][$];
  int          vt  [LANES][$];
  logic [15:0] fcq [$];
  logic [15:0] fc_model = 16'd0;
  logic [LANES-1:0] re_smp;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Lane FIFO models: one-cycle read latency, empty flag tracks contents.
  initial begin
    fifo_data  = '0;
    fifo_empty = '1;
    re_smp     = '0;
    forever begin
      @(negedge clk);
      #2;
      for (int k = 0; k < LANES; k++) fifo_empty[k] = (fq[k].size() == 0);
      #1;
      re_smp = fifo_re;
      @(posedge clk);
      #1;
      for (int k = 0; k < LANES; k++) begin
        if (re_smp[k]) begin
          rd_cnt++;
          chk($sformatf("fifo_nonempty_on_read_lane%0d", k), fq[k].size() != 0, 1);
          if (fq[k].size() != 0) fifo_data[8*k +: 8] = fq[k].pop_front();
        end
      end
      for (int k = 0; k < LANES; k++) fifo_empty[k] = (fq[k].size() == 0);
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents data or done.
  always @(negedge clk) begin
    if (resetn) begin
      for (int k = 0; k < LANES; k++) begin
        if (pe_valid[k]) begin
          vt[k].push_back(cyc_n);
          if (exq[k].size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_pe_valid lane%0d: got data %0h, expected no valid", k, pe_data[8*k +: 8]);
          end else begin
            chk($sformatf("pe_data_lane%0d", k), pe_data[8*k +: 8], exq[k].pop_front());
          end
        end
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc_n;
        if (fcq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 with count %0h, expected no done", frame_count);
        end else begin
          chk("frame_count_at_done", frame_count, fcq.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [7:0] std_byte(input int k, input int i, input logic [7:0] salt);
    logic [7:0] b;
    b = (i >= 2 && i <= 5) ? 8'(8'h11 * (4*k + i - 1)) : 8'h00;
    return b ^ salt;
  endfunction

  task automatic push(input int k, input logic [7:0] b);
    fq[k].push_back(b);
    exq[k].push_back(b);
  endtask

  task automatic load_frame(input logic [7:0] salt, input int lane2_bytes);
    for (int k = 0; k < LANES; k++)
      for (int i = 0; i < FRAME; i++)
        if (k != LANES-1 || i < lane2_bytes) push(k, std_byte(k, i, salt));
  endtask

  task automatic start_frame();
    start = 1'b1;
    fc_model = fc_model + 16'd1;
    fcq.push_back(fc_model);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int n0, input int max_cyc);
    for (int i = 0; i < max_cyc && done_cnt == n0; i++) tick();
    if (done_cnt == n0) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got no done in %0d cycles, expected one", max_cyc);
    end
  endtask

  task automatic clear_timing();
    for (int k = 0; k < LANES; k++) vt[k].delete();
    busy_cnt = 0;
    rd_cnt   = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    int n0;
    int d;

    // Reset state
    tick();
    tick();
    chk("reset_fifo_re", fifo_re, 0);
    chk("reset_pe_valid", pe_valid, 0);
    chk("reset_pe_data", pe_data, 0);
    chk("reset_busy_done_stall", {busy, done, stall}, 0);
    chk("reset_frame_count", frame_count, 0);
    resetn = 1'b1;
    tick();

    // Single frame, no stalls
    load_frame(8'h00, FRAME);
    tick();
    clear_timing();
    c = cyc_n;
    n0 = done_cnt;
    start_frame();
    chk("run_c1_fifo_re", fifo_re, 3'b001);
    chk("run_c1_busy", busy, 1);
    tick();
    chk("run_c2_fifo_re", fifo_re, 3'b011);
    tick();
    chk("run_c3_fifo_re", fifo_re, 3'b111);
    wait_done(n0, 30);
    chk("single_done_latency", done_cyc - c, 11);
    chk("single_frame_count", frame_count, 1);
    chk("single_busy_cycles", busy_cnt, 10);
    chk("single_reads", rd_cnt, 21);
    chk("lane0_first_valid", vt[0].size() > 0 ? vt[0][0] - c : -1, 3);
    for (int k = 0; k < LANES; k++) begin
      chk($sformatf("lane%0d_valid_count", k), vt[k].size(), FRAME);
      if (vt[k].size() == FRAME) begin
        chk($sformatf("lane%0d_skew", k), vt[k][0] - vt[0][0], k);
        chk($sformatf("lane%0d_contiguous", k), vt[k][FRAME-1] - vt[k][0], FRAME-1);
      end
    end

    // Stall: lane 2 starts with only 3 bytes, refilled after the stall begins
    tick();
    load_frame(8'h5A, 3);
    tick();
    clear_timing();
    c = cyc_n;
    n0 = done_cnt;
    start_frame();
    for (int j = 2; j <= 8; j++) begin
      tick();
      chk($sformatf("stall_cyc%0d", j), stall, (j >= 6) ? 1 : 0);
      if (j >= 6) chk($sformatf("stall_re_cyc%0d", j), fifo_re, 0);
    end
    for (int i = 3; i < FRAME; i++) push(LANES-1, std_byte(LANES-1, i, 8'h5A));
    wait_done(n0, 30);
    chk("stall_done_latency", done_cyc - c, 13);
    chk("stall_reads", rd_cnt, 21);
    chk("stall_frame_count", frame_count, 2);

    // Start while busy is ignored
    tick();
    load_frame(8'hA5, FRAME);
    tick();
    c = cyc_n;
    n0 = done_cnt;
    start_frame();
    repeat (4) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n0, 30);
    chk("busy_start_done_latency", done_cyc - c, 11);
    repeat (15) tick();
    chk("busy_start_single_done", done_cnt - n0, 1);
    chk("busy_start_frame_count", frame_count, 3);
    chk("busy_start_idle", {busy, fifo_re}, 0);

    // Back-to-back frames
    load_frame(8'h33, FRAME);
    load_frame(8'hCC, FRAME);
    tick();
    n0 = done_cnt;
    start_frame();
    wait_done(n0, 30);
    chk("b2b_done_seen", done, 1);
    d = cyc_n;
    start_frame();
    chk("b2b_second_busy", busy, 1);
    wait_done(n0 + 1, 30);
    chk("b2b_done_latency", done_cyc - d, 11);
    chk("b2b_frame_count", frame_count, 5);

    // Reset mid-frame
    tick();
    load_frame(8'h77, FRAME);
    tick();
    start_frame();
    repeat (3) tick();
    resetn = 1'b0;
    #1;
    chk("midreset_fifo_re", fifo_re, 0);
    chk("midreset_pe_valid", pe_valid, 0);
    chk("midreset_pe_data", pe_data, 0);
    chk("midreset_busy_done_stall", {busy, done, stall}, 0);
    chk("midreset_frame_count", frame_count, 0);
    for (int k = 0; k < LANES; k++) begin
      fq[k].delete();
      exq[k].delete();
    end
    fcq.delete();
    fc_model = 16'd0;
    tick();
    load_frame(8'h01, FRAME);
    tick();
    resetn = 1'b1;
    for (int j = 0; j < 4; j++) begin
      tick();
      chk($sformatf("post_reset_idle%0d", j), {busy, fifo_re}, 0);
    end
    n0 = done_cnt;
    start_frame();
    wait_done(n0, 30);
    chk("post_reset_frame_count", frame_count, 1);

    // Frame counter wrap
    tick();
    force dut.frame_count = 16'hFFFF;
    tick();
    release dut.frame_count;
    fc_model = 16'hFFFF;
    tick();
    chk("wrap_preset", frame_count, 16'hFFFF);
    load_frame(8'hE7, FRAME);
    tick();
    n0 = done_cnt;
    start_frame();
    wait_done(n0, 30);
    chk("wrap_frame_count", frame_count, 16'h0000);

    repeat (3) tick();
    for (int k = 0; k < LANES; k++) chk($sformatf("scoreboard_drained_lane%0d", k), exq[k].size(), 0);
    chk("scoreboard_done_drained", fcq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/array_feed_skewer.md
# array_feed_skewer

Downstream consumer of the three alignment lanes (each an alignment top with its byte FIFO) in the 3x3 array path. On a start pulse it drains one 7-byte frame from every lane FIFO using a diagonal skew, where lane k begins reading k cycles after lane 0. It presents the bytes to the PE array row inputs with per-lane valids. If any FIFO due for a read is empty, the whole engine stalls in lockstep so the skew is never broken.

## Interface
- LANES, 3, number of alignment lanes / array rows
- FRAME, 7, bytes read per lane per frame (matches sequencer frame 0,0,B0,B1,B2,B3,0)
- clk  in  1  single system clock, all state on rising edge
- resetn  in  1  asynchronous active-low reset
- start  in  1  request one frame; sampled only in IDLE
- fifo_empty  in  LANES  per-lane alignment FIFO empty flag
- fifo_data  in  8*LANES  per-lane FIFO dataout, lane k at [8k+7:8k]
- fifo_re  out  LANES  per-lane FIFO read enable (drives global_re of lane k)
- pe_data  out  8*LANES  registered byte to PE row k
- pe_valid  out  LANES  pe_data lane k valid this cycle
- busy  out  1  high in RUN and FLUSH
- done  out  1  one-cycle pulse when frame fully delivered
- stall  out  1  high on RUN cycles where the engine holds
- frame_count  out  16  frames completed, wraps 0xFFFF->0

## Operation
- States: IDLE, RUN, FLUSH.
- IDLE: all fifo_re=0. start=1 -> RUN, cyc<=0. start in RUN/FLUSH is ignored, not queued.
- RUN: cyc counts 0..FRAME+LANES-2 (0..8 by default). Width is ceil(log2(FRAME+LANES-1)).
- Lane k wants a read when k <= cyc <= k+FRAME-1.
- stall = OR over k of (want_k & fifo_empty[k]).
- If stall=1: fifo_re=0 on all lanes and cyc holds.
- Else: fifo_re[k]=want_k, and cyc increments.
- On the non-stalled cycle with cyc=FRAME+LANES-2 -> FLUSH.
- FLUSH: one cycle, fifo_re=0. Captures the last lane's data. Next state is IDLE, with done=1 and frame_count+1 in that same transition.
- FIFO read latency is 1: data for a read issued in cycle t is on fifo_data in t+1.
- re_q[k] <= fifo_re[k]. When re_q[k]=1, pe_data[k] <= fifo_data[k] and pe_valid[k] <= 1. Otherwise pe_valid[k] <= 0 and pe_data[k] holds.
- No reads are issued to a lane outside its window, even if its FIFO is non-empty.
- Exactly FRAME reads per lane per frame; total reads per frame = LANES*FRAME (21).

## Timing
- Reset values: state=IDLE, cyc=0, fifo_re=0, pe_data=0, pe_valid=0, busy=0, done=0, stall=0, frame_count=0, re_q=0.
- fifo_re and stall are combinational from state, cyc and fifo_empty. All other outputs are registered.
- start at edge t: RUN at t+1, and fifo_re[0] is asserted in that cycle if lane 0 is non-empty.
- pe_valid[k] trails fifo_re[k] by 1 cycle, then one further cycle for the output register. Net: a byte read at t appears on pe_data at t+2.
- No-stall frame: busy for FRAME+LANES-1+1 = 10 cycles. done is asserted in the cycle after FLUSH, coincident with the last pe_valid[LANES-1].
- Skew preserved: with no stalls, pe_valid[k] rises exactly k cycles after pe_valid[0]. A stall inserts the same bubble into every active lane.
- Simultaneous empty on multiple lanes: a single stall, no partial reads.
- Reset mid-frame: immediate return to reset values. Partially drained FIFO contents are not restored; the upstream flush is a system-level responsibility.
- frame_count wraps silently.

## Test plan
- Single frame: preload lane0=00,00,11,22,33,44,00; lane1=00,00,55,66,77,88,00; lane2=00,00,99,AA,BB,CC,00; pulse start. Required response: each lane delivers its 7 bytes in order, pe_valid[1] one cycle after [0] and [2] two cycles after, done 11 cycles after start, frame_count=1.
- Stall: lane2 holds only 3 bytes at start; refill it 5 cycles later. Required response: stall=1 from cyc=5 until the refill, fifo_re=0 on all lanes while stalled, byte order and relative skew unchanged, 21 reads total.
- Start while busy: pulse start again at cyc=4. Required response: ignored, only one done, frame_count=1.
- Back-to-back: pulse start on the cycle done is high and the engine is in IDLE. Required response: the second frame starts the next cycle, frame_count=2 after the second done.
- Reset mid-frame: deassert resetn at cyc=3. Required response: all outputs 0 asynchronously; after release, state is IDLE and no fifo_re issues until the next start.
- Wrap: force frame_count=FFFF, then run one frame. Required response: frame_count=0000.
